// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables/flushes for memory waits, load-use bubbles
// and taken-branch flushes, with a sticky timeout fault. Optional counters: HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic [4:0] idex_rd,
  input  logic       idex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush_n,
  output logic       idex_flush_n,
  output logic       exmem_flush_n,
  output logic       memwb_flush_n,
  output logic [1:0] state,
  output logic       fault
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] LastCnt    = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFault   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            pend_br_q, pend_br_d;

  logic mem_stall;
  logic load_use;
  logic in_fault;
  logic branch_apply;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = idex_mem_read & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  assign in_fault  = (state_q == StFault);
  // A branch seen while stalled is held in pend_br and applied in the first free cycle.
  assign branch_apply = ~in_fault & ~mem_stall & (ex_branch_taken | pend_br_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      pend_br_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_br_q  <= pend_br_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = CntW'(1);
        end
      end
      StMemWait: begin
        if (!mem_stall) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == LastCnt) begin
          // This edge closes the TIMEOUT-th consecutive waiting cycle.
          state_d    = StFault;
          wait_cnt_d = TimeoutCnt;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pend_br_d = 1'b0;
    if (!in_fault && mem_stall) begin
      pend_br_d = pend_br_q | ex_branch_taken;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush_n  = 1'b1;
    idex_flush_n  = 1'b1;
    exmem_flush_n = 1'b1;
    memwb_flush_n = 1'b1;
    if (in_fault) begin
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;
      ifid_flush_n  = 1'b0;
      idex_flush_n  = 1'b0;
      exmem_flush_n = 1'b0;
      memwb_flush_n = 1'b0;
    end else if (mem_stall) begin
      // Freeze the pipe; WB gets a bubble so the stalled access is not retired twice.
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmem_en      = 1'b0;
      memwb_en      = 1'b0;
      memwb_flush_n = 1'b0;
    end else if (branch_apply) begin
      ifid_flush_n = 1'b0;
      idex_flush_n = 1'b0;
    end else if (load_use) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush_n = 1'b0;
    end
  end

  assign state = state_q;
  assign fault = in_fault;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc;

  assign stall_inc = ~pc_en & ~in_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_apply && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n;
  logic [1:0] state;
  logic       fault;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .idex_rd        (idex_rd),
    .idex_mem_read  (idex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush_n   (ifid_flush_n),
    .idex_flush_n   (idex_flush_n),
    .exmem_flush_n  (exmem_flush_n),
    .memwb_flush_n  (memwb_flush_n),
    .state          (state),
    .fault          (fault)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [11:0] v;
    bit          perf;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Expected vector: {pc,ifid,idex,exmem,memwb enables, ifid..memwb flush_n, state, fault}
  localparam logic [4:0] EnAll  = 5'b11111;
  localparam logic [4:0] EnNone = 5'b00000;
  localparam logic [4:0] EnLu   = 5'b00111;
  localparam logic [3:0] FnAll  = 4'b1111;
  localparam logic [3:0] FnStl  = 4'b1110;
  localparam logic [3:0] FnBr   = 4'b0011;
  localparam logic [3:0] FnLu   = 4'b1011;
  localparam logic [3:0] FnNone = 4'b0000;

  function automatic logic [11:0] mk(logic [4:0] en, logic [3:0] fn, logic [1:0] st, logic f);
    return {en, fn, st, f};
  endfunction

  task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic mr, input logic br, input logic req, input logic rdy);
    ifid_rs1 = rs1; ifid_rs2 = rs2; idex_rd = rd;
    idex_mem_read = mr; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic step(input string name, input logic [11:0] v, input bit perf = 1'b0,
                      input logic [31:0] sc = 32'd0, input logic [31:0] fc = 32'd0);
    exp_t e;
    e.name = name; e.v = v; e.perf = perf; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n, state, fault};
        checks++;
        if (got !== e.v) $display("FAIL %s: got %b want %b", e.name, got, e.v);
        else passed++;
`ifdef HAZARD_CTRL_PERF_EN
        if (e.perf) begin
          checks++;
          if ({stall_cnt, flush_cnt} !== {e.sc, e.fc})
            $display("FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.name, stall_cnt, flush_cnt, e.sc, e.fc);
          else passed++;
        end
`endif
      end
    end
  end

  initial begin : stim
    reset = 1'b0;
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step("reset", mk(EnAll, FnAll, 2'd0, 1'b0), 1'b1, 32'd0, 32'd0);
    reset = 1'b1;

    drv(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("normal_load_nodep", mk(EnAll, FnAll, 2'd0, 1'b0));
    drv(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("load_use_rs2", mk(EnLu, FnLu, 2'd0, 1'b0));
    drv(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_bubble", mk(EnAll, FnAll, 2'd0, 1'b0));
    drv(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("load_rd0_no_bubble", mk(EnAll, FnAll, 2'd0, 1'b0));

    // 3-cycle memory wait
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("memwait_c1", mk(EnNone, FnStl, 2'd0, 1'b0));
    step("memwait_c2", mk(EnNone, FnStl, 2'd1, 1'b0));
    step("memwait_c3", mk(EnNone, FnStl, 2'd1, 1'b0));
    mem_ready = 1'b1;
    step("memwait_done", mk(EnAll, FnAll, 2'd1, 1'b0));
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("memwait_back_run", mk(EnAll, FnAll, 2'd0, 1'b0), 1'b1, 32'd4, 32'd0);

    // Branch arriving in the 2nd stall cycle is held until the stall ends
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("brstall_c1", mk(EnNone, FnStl, 2'd0, 1'b0));
    ex_branch_taken = 1'b1;
    step("brstall_c2_taken", mk(EnNone, FnStl, 2'd1, 1'b0));
    ex_branch_taken = 1'b0;
    step("brstall_c3", mk(EnNone, FnStl, 2'd1, 1'b0));
    mem_ready = 1'b1;
    step("brstall_pending_flush", mk(EnAll, FnBr, 2'd1, 1'b0));
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("brstall_pend_cleared", mk(EnAll, FnAll, 2'd0, 1'b0));

    drv(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step("branch_plus_load_use", mk(EnAll, FnBr, 2'd0, 1'b0));
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch_run", mk(EnAll, FnBr, 2'd0, 1'b0), 1'b1, 32'd7, 32'd2);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle", mk(EnAll, FnAll, 2'd0, 1'b0), 1'b1, 32'd7, 32'd3);

    // Timeout: 4 waiting cycles then FAULT
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_w1", mk(EnNone, FnStl, 2'd0, 1'b0));
    step("to_w2", mk(EnNone, FnStl, 2'd1, 1'b0));
    step("to_w3", mk(EnNone, FnStl, 2'd1, 1'b0));
    step("to_w4", mk(EnNone, FnStl, 2'd1, 1'b0));
    step("fault_entered", mk(EnNone, FnNone, 2'd2, 1'b1));
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("fault_sticky", mk(EnNone, FnNone, 2'd2, 1'b1), 1'b1, 32'd11, 32'd3);
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("reset_mid_fault", mk(EnAll, FnAll, 2'd0, 1'b0), 1'b1, 32'd0, 32'd0);
    reset = 1'b1;
    step("run_after_fault_reset", mk(EnAll, FnAll, 2'd0, 1'b0));

    // Reset mid-stall discards a pending branch
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("rst_stall_c1_br", mk(EnNone, FnStl, 2'd0, 1'b0));
    ex_branch_taken = 1'b0;
    step("rst_stall_c2", mk(EnNone, FnStl, 2'd1, 1'b0));
    mem_req = 1'b0;
    reset = 1'b0;
    step("reset_mid_stall", mk(EnAll, FnAll, 2'd0, 1'b0));
    reset = 1'b1;
    step("pend_discarded", mk(EnAll, FnAll, 2'd0, 1'b0));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
